// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus per-channel debounce FSMs for the board switches.
// oSW[i] feeds iAND_(i+1) of the AND/OR stage; oChange strobes on any accepted update.

module input_debouncer_chan #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic iReset,
  input  logic i_s,
  output logic o_level,
  output logic o_accept,
  output logic o_busy
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  localparam logic [CW-1:0] LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam bit            SINGLE   = (DEBOUNCE_CYCLES == 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_level;
  logic          w_diff;
  logic          w_accept;

  assign w_diff = (i_s != r_level);

  always_ff @(posedge clk) begin
    if (iReset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) r_level <= i_s;
    end
  end

  // cnt == 0 exactly when in IDLE, so oBusy can be derived from the counter alone.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_diff && !SINGLE) begin
          w_state_nxt = COUNT;
          w_cnt_nxt   = ONE;
        end
      end
      COUNT: begin
        if (!w_diff || w_accept) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    unique case (r_state)
      IDLE:    w_accept = w_diff && SINGLE;
      COUNT:   w_accept = w_diff && (r_cnt == LAST);
      default: w_accept = 1'b0;
    endcase
  end

  assign o_level  = r_level;
  assign o_accept = w_accept;
  assign o_busy   = (r_cnt != '0);

endmodule

module input_debouncer #(
  parameter int N_INPUTS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                iReset,
  input  logic [N_INPUTS-1:0] iSW,
  output logic [N_INPUTS-1:0] oSW,
  output logic                oChange,
  output logic                oBusy
);

  logic [N_INPUTS-1:0] r_sync1, r_sync2;
  logic [N_INPUTS-1:0] w_accept, w_busy;
  logic                r_change;

  always_ff @(posedge clk) begin
    if (iReset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_change <= 1'b0;
    end else begin
      r_sync1  <= iSW;
      r_sync2  <= r_sync1;
      r_change <= |w_accept;
    end
  end

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_chan
    input_debouncer_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .iReset   (iReset),
      .i_s      (r_sync2[i]),
      .o_level  (oSW[i]),
      .o_accept (w_accept[i]),
      .o_busy   (w_busy[i])
    );
  end

  assign oChange = r_change;
  assign oBusy   = |w_busy;

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Synchronises and debounces the four board-level switch inputs before they reach the combinational AND/OR stage (`modulo_1`). Bit i of `oSW` drives `iAND_(i+1)` of that stage. The block removes metastability and contact bounce. It also flags, with a single-cycle strobe, every accepted change of the conditioned vector.

## Interface
- `N_INPUTS`, default 4: number of independent switch channels.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive synchronised cycles a new level must persist before it is accepted. Legal range is ≥ 1. The default is 10 ms at 100 MHz.
- `clk`, input, 1 bit: single system clock; all logic on the rising edge.
- `iReset`, input, 1 bit: reset, synchronous and active-high.
- `iSW`, input, `N_INPUTS` bits: raw asynchronous switch levels.
- `oSW`, output, `N_INPUTS` bits: debounced levels, registered; bit i feeds `iAND_(i+1)`.
- `oChange`, output, 1 bit: registered one-cycle pulse on each edge where any `oSW` bit updates.
- `oBusy`, output, 1 bit: high while any channel is in COUNT.

## Operation
- **Synchroniser:** two flops per bit, `iSW` → `sync1` → `sync2`. The debounce logic sees only `s = sync2`.
- **Per-channel FSM:** one state machine per channel with counter `cnt`, width `clog2(DEBOUNCE_CYCLES+1)`.
  - **IDLE** (`cnt == 0`): if `s[i] != oSW[i]`, go to COUNT with `cnt <= 1`. If `DEBOUNCE_CYCLES == 1`, accept immediately instead (see below). Otherwise stay.
  - **COUNT:** if `s[i] == oSW[i]`, this is a glitch. Return to IDLE with `cnt <= 0`; no output change, no strobe.
  - **COUNT:** else if `cnt == DEBOUNCE_CYCLES-1`, accept. `oSW[i] <= s[i]`, `cnt <= 0`, go to IDLE.
  - **COUNT:** else `cnt <= cnt + 1`.
- **Acceptance rule:** a level is accepted on the edge where it has been observed on `s[i]` for `DEBOUNCE_CYCLES` consecutive edges.
- **Channel independence:** channels share no state. Simultaneous acceptances on several bits update all of them on the same edge.
- **`oChange`:** `oChange <= |(accept vector)`. Several bits accepted on one edge produce one pulse, not several.
- **`oBusy`:** OR over channels of `cnt != 0`. It is combinational from registers and has no extra latency.
- **Counter bound:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- **Reset:** when `iReset` is high at an edge, `sync1`, `sync2`, `cnt`, `oSW` and `oChange` are all cleared to 0.
  - Reset overrides every other action, including an acceptance due on the same edge.
  - Reset during COUNT aborts the count; `oSW` goes to 0 regardless of prior level.

## Timing
- **Reset values:** `oSW = 0`, `oChange = 0`, `oBusy = 0`.
- **Latency:** `iSW` changes, stable, ahead of rising edge E1. `oSW` and `oChange` update on edge E(`DEBOUNCE_CYCLES`+2).
  - 2 edges are for synchronisation; `DEBOUNCE_CYCLES` edges are for qualification.
- **`oBusy` window:** rises after edge E3. It falls on the acceptance edge unless another channel is still counting.
- **Glitch rejection:** a pulse on `s[i]` shorter than `DEBOUNCE_CYCLES` cycles produces no `oSW` or `oChange` activity.
  - `oBusy` is high only for the pulse duration.
- **Reversal:** a reversal that restores `s[i] == oSW[i]` resets the count. The next deviation starts again from 1.
- **Back-to-back changes:** the new level after an acceptance is measured from scratch. The minimum spacing between two `oChange` pulses for one channel is `DEBOUNCE_CYCLES` cycles.
- **After reset release:** with `iSW` held nonzero, `oSW` follows after `DEBOUNCE_CYCLES`+2 edges counted from the first edge with `iReset` low.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`, `N_INPUTS = 4`, and a 20-time-unit clock.
1. **Reset:** hold `iReset` high 3 edges with `iSW = 4'hF`. Require `oSW = 0`, `oChange = 0` and `oBusy = 0` throughout; release, then require `oSW = 4'hF` on edge 6 after release and `oChange` high exactly that one cycle.
2. **Single bit, clean step:** with `oSW = 0`, set `iSW = 4'h1` before E1. Require `oSW = 4'h1` and a one-cycle `oChange` at E6. `oBusy` must be high from after E3 through E5.
3. **Glitch:** set `iSW[2]` high for 3 cycles, then low. Require `oSW` unchanged and `oChange` never asserted; `oBusy` pulses only while `s[2]` differs.
4. **Simultaneous bits:** step `iSW` from `4'h0` to `4'hA` in one cycle. Require `oSW = 4'hA` at E6 with a single one-cycle `oChange`.
5. **Reset mid-count:** with `oSW = 4'h0`, set `iSW = 4'h3`, then assert `iReset` at E4 for 1 edge. Require `oSW = 0` and `oChange = 0` after E4; `oSW = 4'h3` must appear 6 edges after release.
6. **Full sweep:** drive `iSW` through `4'h0` to `4'hF`, incrementing every 8 cycles, with `modulo_1` attached. Require every value to appear on `oSW` 6 edges after it is applied, with exactly 15 `oChange` pulses in total.
